// File: rtl/aes_axis_block_packer.sv
// Packs a 32-bit AXI-Stream byte stream into 128-bit blocks for the AES-256 CTR core.
// Optional PKCS#7 padding with an extra pad block is enabled by defining AES_PACK_PKCS7_EN.
module aes_axis_block_packer #(
    parameter int         CNT_W    = 32,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [31:0]        s_axis_tdata,
    input  logic [3:0]         s_axis_tkeep,
    input  logic               s_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [127:0]       m_axis_tdata,
    output logic [15:0]        m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic [CNT_W-1:0]   block_count,
    output logic               err_tkeep
);

    typedef enum logic {ST_ACC = 1'b0, ST_PAD = 1'b1} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            wcnt_reg;
    logic [3:0][31:0]      acc_data_reg;
    logic [3:0][3:0]       acc_keep_reg;
    logic                  m_valid_reg;
    logic [127:0]          m_data_reg;
    logic [15:0]           m_keep_reg;
    logic                  m_last_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  err_reg;

    logic                  out_free, accept, close, pad_load, go_pad, block_last, keep_bad;
    logic [1:0]            lane_sel;
    logic [3:0][31:0]      merged_data;
    logic [3:0][3:0]       merged_keep;
    logic [127:0]          data_flat, fill_data;
    logic [15:0]           keep_flat;
    logic [7:0]            pad_value;

    assign lane_sel      = 2'd3 - wcnt_reg;
    assign out_free      = !m_valid_reg || m_axis_tready;
    assign s_axis_tready = (state_reg == ST_ACC) && out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign close         = accept && (s_axis_tlast || wcnt_reg == 2'd3);
    assign pad_load      = (state_reg == ST_PAD) && out_free;

    // Lanes above the write lane were filled earlier; lanes below it are still empty.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign merged_keep[gi] = (LANE == lane_sel) ? s_axis_tkeep :
                                     (LANE > lane_sel)  ? acc_keep_reg[gi] : 4'h0;
            assign merged_data[gi] = (LANE == lane_sel) ? s_axis_tdata : acc_data_reg[gi];
        end
    endgenerate

    assign keep_flat = merged_keep;
    assign data_flat = merged_data;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign fill_data[gi*8 +: 8] = keep_flat[gi] ? data_flat[gi*8 +: 8] : pad_value;
        end
    endgenerate

`ifdef AES_PACK_PKCS7_EN
    // Every unkept byte carries the pad length; a full last block defers tlast to the pad block.
    assign pad_value  = 8'd16 - 8'($countones(keep_flat));
    assign go_pad     = close && s_axis_tlast && (keep_flat == 16'hFFFF);
    assign block_last = s_axis_tlast && !go_pad;
`else
    assign pad_value  = PAD_BYTE;
    assign go_pad     = 1'b0;
    assign block_last = s_axis_tlast;
`endif

    always_comb begin
        keep_bad = 1'b0;
        if (s_axis_tlast) begin
            case (s_axis_tkeep)
                4'hF, 4'hE, 4'hC, 4'h8, 4'h0: keep_bad = 1'b0;
                default:                      keep_bad = 1'b1;
            endcase
        end else begin
            keep_bad = (s_axis_tkeep != 4'hF);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACC:  if (go_pad) state_next = ST_PAD;
            ST_PAD:  if (pad_load) state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_reg     <= 2'd0;
            acc_data_reg <= '0;
            acc_keep_reg <= '0;
        end else if (accept) begin
            acc_data_reg[lane_sel] <= s_axis_tdata;
            acc_keep_reg[lane_sel] <= s_axis_tkeep;
            wcnt_reg               <= close ? 2'd0 : wcnt_reg + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_keep_reg  <= '0;
            m_last_reg  <= 1'b0;
        end else if (close) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= fill_data;
            m_keep_reg  <= keep_flat;
            m_last_reg  <= block_last;
        end else if (pad_load) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= {16{8'h10}};
            m_keep_reg  <= 16'h0000;
            m_last_reg  <= 1'b1;
        end else if (m_axis_tready) begin
            m_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (m_valid_reg && m_axis_tready) count_reg <= count_reg + CNT_W'(1);
            if (accept && keep_bad)           err_reg   <= 1'b1;
        end
    end

    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tkeep  = m_keep_reg;
    assign m_axis_tlast  = m_last_reg;
    assign block_count   = count_reg;
    assign err_tkeep     = err_reg;

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// Directed bench for aes_axis_block_packer; expectations track AES_PACK_PKCS7_EN when defined.
module tb_aes_axis_block_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [31:0]  s_axis_tdata = '0;
    logic [3:0]   s_axis_tkeep = '0;
    logic         s_axis_tlast = 1'b0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [31:0]  block_count;
    logic         err_tkeep;

    int errors = 0;
    int checks = 0;
    int stall_cycles = 0;

    always #5 clk = ~clk;

    aes_axis_block_packer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .block_count   (block_count),
        .err_tkeep     (err_tkeep)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a word at the falling edge and returns one falling edge after it is accepted.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int waits;
        waits = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (!s_axis_tready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        stall_cycles += waits;
        check("ready_timeout", 128'(waits >= 50), 128'(1'b0));
        @(posedge clk);
        @(negedge clk);
        $display("word %h keep %h last %0d accepted after %0d stalls", d, k, l, waits);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_block(input string tag, input logic [127:0] d, input logic [15:0] k,
                               input logic l);
        check({tag, "_valid"}, 128'(m_axis_tvalid), 128'(1'b1));
        check({tag, "_data"},  m_axis_tdata, d);
        check({tag, "_keep"},  128'(m_axis_tkeep), 128'(k));
        check({tag, "_last"},  128'(m_axis_tlast), 128'(l));
        $display("block %s data %h keep %h last %0d count %0d", tag, m_axis_tdata, m_axis_tkeep,
                 m_axis_tlast, block_count);
    endtask

    localparam logic [127:0] BLK_A   = 128'h6BC1BEE2_2E409F96_E93D7E11_7393172A;
    localparam logic [127:0] BLK_PAD = {16{8'h10}};
`ifdef AES_PACK_PKCS7_EN
    localparam logic [127:0] BLK_B2  = 128'hAE2D0E0E_0E0E0E0E_0E0E0E0E_0E0E0E0E;
    localparam logic [127:0] BLK_C   = 128'h01223344_55667788_99AABBCC_DDEEFF00;
    localparam logic [127:0] BLK_D   = BLK_PAD;
    localparam logic         FULL_LAST = 1'b0;
    localparam int           CNT_A = 2, CNT_B = 4, CNT_C = 5, CNT_D = 6, CNT_E = 9;
`else
    localparam logic [127:0] BLK_B2  = 128'hAE2D0000_00000000_00000000_00000000;
    localparam logic [127:0] BLK_C   = 128'h00223344_55667788_99AABBCC_DDEEFF00;
    localparam logic [127:0] BLK_D   = 128'h0;
    localparam logic         FULL_LAST = 1'b1;
    localparam int           CNT_A = 1, CNT_B = 3, CNT_C = 4, CNT_D = 5, CNT_E = 7;
`endif
    localparam logic [127:0] BLK_F   = 128'hF69F2445_DF4F9B17_AD2B417B_E66C3710;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 128'(m_axis_tvalid), 128'(1'b0));
        check("rst_data",  m_axis_tdata, 128'h0);
        check("rst_keep",  128'(m_axis_tkeep), 128'h0);
        check("rst_last",  128'(m_axis_tlast), 128'(1'b0));
        check("rst_count", 128'(block_count), 128'h0);
        check("rst_err",   128'(err_tkeep), 128'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        // Full block held under backpressure
        m_axis_tready = 1'b0;
        send_word(32'h6BC1BEE2, 4'hF, 1'b0);
        send_word(32'h2E409F96, 4'hF, 1'b0);
        send_word(32'hE93D7E11, 4'hF, 1'b0);
        send_word(32'h7393172A, 4'hF, 1'b1);
        idle();
        check_block("full", BLK_A, 16'hFFFF, FULL_LAST);
        for (int i = 0; i < 10; i++) begin
            check("stall_ready", 128'(s_axis_tready), 128'(1'b0));
            check("stall_data",  m_axis_tdata, BLK_A);
            check("stall_valid", 128'(m_axis_tvalid), 128'(1'b1));
            @(negedge clk);
        end
        check("stall_count", 128'(block_count), 128'h0);
        m_axis_tready = 1'b1;
        @(negedge clk);
`ifdef AES_PACK_PKCS7_EN
        check_block("pad_a", BLK_PAD, 16'h0000, 1'b1);
        @(negedge clk);
`endif
        check("a_valid", 128'(m_axis_tvalid), 128'(1'b0));
        check("a_count", 128'(block_count), 128'(CNT_A));

        // Partial close on the fifth word
        send_word(32'h6BC1BEE2, 4'hF, 1'b0);
        send_word(32'h2E409F96, 4'hF, 1'b0);
        send_word(32'hE93D7E11, 4'hF, 1'b0);
        send_word(32'h7393172A, 4'hF, 1'b0);
        check_block("b1", BLK_A, 16'hFFFF, 1'b0);
        send_word(32'hAE2D8A57, 4'hC, 1'b1);
        idle();
        check_block("b2", BLK_B2, 16'hC000, 1'b1);
        @(negedge clk);
        check("b_valid", 128'(m_axis_tvalid), 128'(1'b0));
        check("b_count", 128'(block_count), 128'(CNT_B));
        check("b_err",   128'(err_tkeep), 128'(1'b0));

        // Malformed keep on a non-last word
        send_word(32'h11223344, 4'h7, 1'b0);
        check("c_err_set", 128'(err_tkeep), 128'(1'b1));
        send_word(32'h55667788, 4'hF, 1'b0);
        send_word(32'h99AABBCC, 4'hF, 1'b0);
        send_word(32'hDDEEFF00, 4'hF, 1'b1);
        idle();
        check_block("c", BLK_C, 16'h7FFF, 1'b1);
        @(negedge clk);
        check("c_count", 128'(block_count), 128'(CNT_C));

        // Empty close
        send_word(32'h12345678, 4'h0, 1'b1);
        idle();
        check_block("empty", BLK_D, 16'h0000, 1'b1);
        @(negedge clk);
        check("d_count", 128'(block_count), 128'(CNT_D));
        check("d_err_sticky", 128'(err_tkeep), 128'(1'b1));

        // Back-to-back words never stall the input
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            send_word(32'hA0000000 | 32'(i), 4'hF, i == 7);
        end
        idle();
        check_block("e2", 128'hA0000004_A0000005_A0000006_A0000007, 16'hFFFF, FULL_LAST);
        check("e_stalls", 128'(stall_cycles), 128'h0);
        repeat (3) @(negedge clk);
        check("e_count", 128'(block_count), 128'(CNT_E));

        // Asynchronous reset mid-packet
        send_word(32'hDEADBEEF, 4'hF, 1'b0);
        send_word(32'hCAFEF00D, 4'hF, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 128'(m_axis_tvalid), 128'(1'b0));
        check("arst_data",  m_axis_tdata, 128'h0);
        check("arst_keep",  128'(m_axis_tkeep), 128'h0);
        check("arst_last",  128'(m_axis_tlast), 128'(1'b0));
        check("arst_count", 128'(block_count), 128'h0);
        check("arst_err",   128'(err_tkeep), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        send_word(32'hF69F2445, 4'hF, 1'b0);
        send_word(32'hDF4F9B17, 4'hF, 1'b0);
        send_word(32'hAD2B417B, 4'hF, 1'b0);
        send_word(32'hE66C3710, 4'hF, 1'b1);
        idle();
        check_block("f", BLK_F, 16'hFFFF, FULL_LAST);
        check("f_ready", 128'(s_axis_tready), 128'(FULL_LAST));
        @(negedge clk);
`ifdef AES_PACK_PKCS7_EN
        check_block("pad_f", BLK_PAD, 16'h0000, 1'b1);
        check("pad_f_ready", 128'(s_axis_tready), 128'(1'b1));
        @(negedge clk);
        check("f_count", 128'(block_count), 128'(2));
`else
        check("f_count", 128'(block_count), 128'(1));
`endif
        check("f_valid", 128'(m_axis_tvalid), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_axis_block_packer.md
Name: aes_axis_block_packer

Overview:
- Upstream feeder for the AES-256 CTR core.
- Packs a 32-bit AXI-Stream byte stream, with tkeep, into 128-bit AXI-Stream blocks that drive the core's s_axis_* inputs.
- Closes a partial final block on tlast by padding it and reporting valid bytes on a sideband m_axis_tkeep.
- Counts emitted blocks and flags malformed tkeep.

Parameters:
- CNT_W, 32, width of block counter output.
- PAD_BYTE, 8'h00, fill byte for the partial final block when the optional feature is off.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous, active-high
- s_axis_tvalid  in  1  input word valid
- s_axis_tready  out  1  input word accepted
- s_axis_tdata  in  32  input word; first byte on the wire in [31:24]
- s_axis_tkeep  in  4  byte enables; tkeep[3] qualifies [31:24]
- s_axis_tlast  in  1  last word of packet
- m_axis_tvalid  out  1  block valid, to CTR core s_axis_tvalid
- m_axis_tready  in  1  from CTR core s_axis_tready
- m_axis_tdata  out  128  packed block; word 0 in [127:96]
- m_axis_tkeep  out  16  byte enables; bit 15 qualifies [127:120]
- m_axis_tlast  out  1  last block of packet
- block_count  out  CNT_W  blocks emitted since reset (handshakes on m side)
- err_tkeep  out  1  sticky error flag, cleared only by rst

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, block_count=0, err_tkeep=0. Internal word count=0, FSM=ACC.
- Storage:
  - Accumulator: 4x32 bits plus keep bits.
  - One output register holding m_axis_* fields.
- Ready rule: s_axis_tready = FSM==ACC and (!m_axis_tvalid or m_axis_tready). It never depends on s_axis_tvalid.
- Accept: a word transfers when s_axis_tvalid and s_axis_tready are both high.
  - The word is written at lane 3-wcnt; lane 3 is [127:96].
  - wcnt increments.
- Block close: on an accepted word with wcnt==3 or tlast=1.
  - Accumulator merged with the current word loads the output register next edge. Latency: accept edge N, m_axis_tvalid high after edge N.
  - Unfilled lanes and bytes with tkeep=0 are filled with PAD_BYTE.
  - m_axis_tkeep = concatenation of the lane keeps; unfilled lanes are 0.
  - m_axis_tlast = s_axis_tlast.
  - wcnt returns to 0.
- Output hold: m_axis_* are held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid clears on handshake unless a new block loads the same edge.
  - Back-to-back at 1 word/cycle sustains 1 block per 4 cycles.
- block_count: increments on each m-side handshake and wraps modulo 2^CNT_W.
- tkeep rules. Each violation sets err_tkeep; the data is still packed as given.
  - Non-last word must have tkeep=4'hF.
  - Last word must be contiguous-from-MSB: F, E, C, 8 or 0.
- Empty close: tlast with tkeep=0 and wcnt==0 emits one block with keep=16'h0000 and tlast=1, so the packet boundary is preserved.
- FSM:
  - ACC: normal operation, as above.
  - PAD: used only with the optional feature.
- Reset mid-packet: the partial accumulator is discarded and no block is emitted.

Optional Feature:
- Macro: AES_PACK_PKCS7_EN.
- When defined:
  - Padding follows PKCS#7. Each pad byte = number of pad bytes P (1..16), replacing PAD_BYTE.
  - m_axis_tkeep still marks the original data bytes only.
  - If the closing block is full (keep=FFFF), it is emitted with tlast=0. The FSM then enters PAD with s_axis_tready=0.
  - PAD emits one extra block of sixteen 8'h10 bytes with keep=0000 and tlast=1, then returns to ACC once that block is loaded.
  - Empty close emits the all-8'h10 block.
- When undefined: PAD_BYTE fill, no extra block, and the PAD state is unreachable.

Test Plan:
- Full block: words 6BC1BEE2, 2E409F96, E93D7E11, 7393172A with keep F and tlast on the 4th -> one block 6BC1BEE2_2E409F96_E93D7E11_7393172A, keep FFFF, tlast=1, block_count=1.
- Partial close: 5 words, the 5th AE2D8A57 with keep C and tlast -> block 2 = AE2D0000_00000000_00000000_00000000, keep C000, tlast=1.
  - With AES_PACK_PKCS7_EN: block 2 = AE2D0E0E_0E0E…0E, keep C000.
- Backpressure: hold m_axis_tready=0 for 10 cycles after the first block -> s_axis_tready=0 and m_axis_* held stable; on release, no data is lost or duplicated.
- Malformed keep: non-last word with keep 7 -> err_tkeep=1 and stays 1 until rst.
- Full-block PKCS#7 (macro on): 4 words with tlast -> block tlast=0, then a block of all 8'h10 bytes with keep 0000 and tlast=1; s_axis_tready=0 for one cycle.
- Async reset after 2 accepted words -> all outputs return to their reset values immediately; the next 4 words produce a single clean block.
